// File: rtl/feeder_pkg.sv
// Shared types and constants for the Encrypter feeder: state encoding,
// datapath width defaults and the LFSR rotation-generator constants.
package feeder_pkg;

    localparam int ENCRYPTER_WIDTH    = 32;
    localparam int KEY_ROTATION_WIDTH = 5;

    localparam int DEFAULT_DATA_WIDTH = ENCRYPTER_WIDTH;
    localparam int DEFAULT_ROT_WIDTH  = KEY_ROTATION_WIDTH;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the XOR
    // of bits 0,2,3,5 and enters at bit 15.
    localparam int          LFSR_WIDTH    = 16;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    typedef enum logic [2:0] {
        IDLE_NOKEY,
        WAIT_REQ_K,
        HOLD_K,
        IDLE_READY,
        WAIT_REQ_D,
        SEND_DATA,
        HOLD_D
    } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous plaintext FIFO with occupancy count and full/empty flags.
// Head word is presented combinationally on rdata.
module feeder_fifo
    import feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count alone, which keeps the array free of reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/encrypt_feeder.sv
// Upstream feeder for the Encrypter: sends the key, then buffered plaintext,
// with a per-word rotation offset. Define FEEDER_LFSR_ROT_EN for LFSR rotation.
module encrypt_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ROT_WIDTH   = DEFAULT_ROT_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         key_in,
    input  logic                          key_load,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enc_req,
    output logic [DATA_WIDTH-1:0]         enc_data,
    output logic [ROT_WIDTH-1:0]          enc_rot,
    output logic                          enc_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow
);

    localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;

    feeder_state_t         state;
    feeder_state_t         next_state;
    logic [DATA_WIDTH-1:0] key_reg;
    logic                  key_pending;
    logic [HW-1:0]         hold_cnt;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  send_key;
    logic                  send_data;
    logic [ROT_WIDTH-1:0]  rot_value;

    assign s_ready   = !fifo_full;
    assign push      = s_valid && s_ready;
    assign send_key  = (state == WAIT_REQ_K) && enc_req;
    assign send_data = (state == WAIT_REQ_D) && enc_req;
    assign busy      = !((state == IDLE_NOKEY) || ((state == IDLE_READY) && fifo_empty));

    feeder_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (send_data),
        .wdata (s_data),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE_NOKEY;
            hold_cnt <= '0;
        end else begin
            state <= next_state;
            if (state != next_state) begin
                hold_cnt <= '0;
            end else if ((state == HOLD_K) || (state == HOLD_D)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    // The key pulse lands in the first HOLD_K cycle, so HOLD_K runs one cycle
    // longer than HOLD_D to give the same post-pulse hold.
    // NOTE: next_state gets its default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE_NOKEY: if (key_pending) next_state = WAIT_REQ_K;
            WAIT_REQ_K: if (enc_req) next_state = HOLD_K;
            HOLD_K:     if (hold_cnt == HW'(HOLD_CYCLES)) next_state = IDLE_READY;
            IDLE_READY: begin
                if (key_pending)      next_state = WAIT_REQ_K;
                else if (!fifo_empty) next_state = WAIT_REQ_D;
            end
            WAIT_REQ_D: if (enc_req) next_state = SEND_DATA;
            SEND_DATA:  next_state = HOLD_D;
            HOLD_D:     if (hold_cnt == HW'(HOLD_CYCLES - 1)) next_state = IDLE_READY;
            default:    next_state = IDLE_NOKEY;
        endcase
    end

    // A load in the same cycle as a send wins, so the newer key is sent later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_reg     <= '0;
            key_pending <= 1'b0;
        end else if (key_load) begin
            key_reg     <= key_in;
            key_pending <= 1'b1;
        end else if (send_key) begin
            key_pending <= 1'b0;
        end
    end

`ifdef FEEDER_LFSR_ROT_EN
    logic [LFSR_WIDTH-1:0] lfsr;
    logic                  lfsr_fb;

    assign lfsr_fb   = ^(lfsr & LFSR_TAP_MASK);
    assign rot_value = lfsr[ROT_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (send_key) begin
            lfsr <= LFSR_SEED;
        end else if (send_data) begin
            lfsr <= {lfsr_fb, lfsr[LFSR_WIDTH-1:1]};
        end
    end
`else
    logic [ROT_WIDTH-1:0] rot_cnt;

    assign rot_value = rot_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rot_cnt <= '0;
        end else if (send_key) begin
            rot_cnt <= '0;
        end else if (send_data) begin
            rot_cnt <= rot_cnt + ROT_WIDTH'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_data <= '0;
            enc_rot  <= '0;
            enc_rdy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            enc_rdy <= send_key || send_data;
            if (send_key) begin
                enc_data <= key_reg;
            end else if (send_data) begin
                enc_data <= fifo_head;
                enc_rot  <= rot_value;
            end
            if (s_valid && !s_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_feeder.sv
// Directed self-checking bench for encrypt_feeder (default parameters).
// Expected rotation follows FEEDER_LFSR_ROT_EN when that macro is defined.
module tb_encrypt_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] key_in = '0;
    logic        key_load = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        enc_req = 1'b0;
    logic [31:0] enc_data;
    logic [4:0]  enc_rot;
    logic        enc_rdy;
    logic [3:0]  fifo_count;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [31:0] pulse_data[$];
    logic [4:0]  pulse_rot[$];
    logic        prev_rdy = 1'b0;

    encrypt_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .enc_req    (enc_req),
        .enc_data   (enc_data),
        .enc_rot    (enc_rot),
        .enc_rdy    (enc_rdy),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Rotation expected for the k-th data word since the last key send.
    function automatic logic [4:0] rot_model(input int k);
`ifdef FEEDER_LFSR_ROT_EN
        logic [15:0] l;
        logic        fb;
        l = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            fb = l[0] ^ l[2] ^ l[3] ^ l[5];
            l  = {fb, l[15:1]};
        end
        return l[4:0];
`else
        return 5'(k % 32);
`endif
    endfunction

    // Capture every enc_rdy pulse mid-cycle and flag back-to-back pulses.
    always @(negedge clk) begin
        if (enc_rdy) begin
            check("rdy_gap", {31'b0, prev_rdy}, 32'd0);
            pulse_data.push_back(enc_data);
            pulse_rot.push_back(enc_rot);
        end
        prev_rdy = enc_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        s_data  = w;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        if (!s_ready) check("push_timeout", {31'b0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int want);
        int n;
        n = 0;
        while (pulse_data.size() < want && n < 600) begin
            tick();
            n++;
        end
        if (pulse_data.size() < want) check("pulse_timeout", pulse_data.size(), want);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic clear_pulses();
        pulse_data.delete();
        pulse_rot.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_enc_data", enc_data, 32'd0);
        check("rst_enc_rot", {27'b0, enc_rot}, 32'd0);
        check("rst_enc_rdy", {31'b0, enc_rdy}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_count", {28'b0, fifo_count}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Key send and hold
        enc_req = 1'b1;
        clear_pulses();
        load_key(32'hDEADBEEF);
        wait_pulses(1);
        if (pulse_data.size() >= 1) check("key_data", pulse_data[0], 32'hDEADBEEF);
        check("key_hold1", enc_data, 32'hDEADBEEF);
        check("key_hold1_rdy", {31'b0, enc_rdy}, 32'd0);
        tick();
        check("key_hold2", enc_data, 32'hDEADBEEF);
        wait_idle();
        check("key_single_pulse", pulse_data.size(), 32'd1);

        // Three-word stream
        clear_pulses();
        for (int i = 1; i <= 3; i++) push_word(32'(i));
        wait_pulses(3);
        for (int i = 0; i < 3 && i < pulse_data.size(); i++) begin
            check($sformatf("stream_data%0d", i), pulse_data[i], 32'(i + 1));
            check($sformatf("stream_rot%0d", i), {27'b0, pulse_rot[i]}, {27'b0, rot_model(i)});
        end
        wait_idle();
        check("stream_count", {28'b0, fifo_count}, 32'd0);
        check("stream_no_ovf", {31'b0, overflow}, 32'd0);

        // Fill, overflow, drain
        enc_req = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        check("full_count", {28'b0, fifo_count}, 32'd8);
        check("full_s_ready", {31'b0, s_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd1);
        s_data  = 32'h108;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_count", {28'b0, fifo_count}, 32'd8);
        clear_pulses();
        enc_req = 1'b1;
        wait_pulses(8);
        for (int i = 0; i < 8 && i < pulse_data.size(); i++) begin
            check($sformatf("drain_data%0d", i), pulse_data[i], 32'h100 + 32'(i));
            check($sformatf("drain_rot%0d", i), {27'b0, pulse_rot[i]}, {27'b0, rot_model(3 + i)});
        end
        wait_idle();
        check("drain_count", {28'b0, fifo_count}, 32'd0);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // New key then 33 words: rotation wraps
        clear_pulses();
        load_key(32'h12345678);
        wait_pulses(1);
        if (pulse_data.size() >= 1) check("key2_data", pulse_data[0], 32'h12345678);
        wait_idle();
        clear_pulses();
        for (int i = 0; i < 33; i++) push_word(32'h200 + 32'(i));
        wait_pulses(33);
        for (int i = 0; i < 33 && i < pulse_data.size(); i++) begin
            check($sformatf("wrap_data%0d", i), pulse_data[i], 32'h200 + 32'(i));
            check($sformatf("wrap_rot%0d", i), {27'b0, pulse_rot[i]}, {27'b0, rot_model(i)});
        end
        wait_idle();

        // Key load while a word waits: word, key, then word with fresh rotation
        enc_req = 1'b0;
        clear_pulses();
        push_word(32'h300);
        push_word(32'h301);
        tick();
        tick();
        load_key(32'hCAFEF00D);
        enc_req = 1'b1;
        wait_pulses(3);
        if (pulse_data.size() >= 3) begin
            check("mid_a_data", pulse_data[0], 32'h300);
            check("mid_a_rot", {27'b0, pulse_rot[0]}, {27'b0, rot_model(33)});
            check("mid_key_data", pulse_data[1], 32'hCAFEF00D);
            check("mid_b_data", pulse_data[2], 32'h301);
            check("mid_b_rot", {27'b0, pulse_rot[2]}, {27'b0, rot_model(0)});
        end
        wait_idle();

        // Reset during HOLD_D with two words queued
        enc_req = 1'b0;
        clear_pulses();
        push_word(32'h400);
        push_word(32'h401);
        push_word(32'h402);
        enc_req = 1'b1;
        wait_pulses(1);
        if (pulse_data.size() >= 1) check("hold_word", pulse_data[0], 32'h400);
        check("hold_queued", {28'b0, fifo_count}, 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_data", enc_data, 32'd0);
        check("mid_rst_rot", {27'b0, enc_rot}, 32'd0);
        check("mid_rst_rdy", {31'b0, enc_rdy}, 32'd0);
        check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_count", {28'b0, fifo_count}, 32'd0);
        check("mid_rst_s_ready", {31'b0, s_ready}, 32'd1);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("no_rdy_after_rst", pulse_data.size(), 32'd1);
        check("post_rst_count", {28'b0, fifo_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encrypt_feeder.md
Name: encrypt_feeder

Overview:
- Upstream stage of the Encrypter.
- Accepts a key word and a stream of plaintext words from the host side over valid/ready, buffering the plaintext in a small FIFO.
- Presents the key, then each plaintext word, to the Encrypter through its dataIn/rdyIn/reqIn handshake.
- Generates a per-word rotation offset for the Encrypter's rot_offset input.

Parameters:
- DATA_WIDTH, 32: word width; equals ENCRYPTER_WIDTH and KEY_WIDTH.
- ROT_WIDTH, 5: rotation offset width; equals KEY_ROTATION_WIDTH.
- FIFO_DEPTH, 8: plaintext buffer entries; must be a power of two, at least 2.
- HOLD_CYCLES, 2: cycles that enc_data/enc_rot stay stable after an enc_rdy pulse before enc_req is sampled again; at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- key_in  in  DATA_WIDTH  key word from host
- key_load  in  1  1-cycle strobe; captures key_in and requests a key (re)send
- s_data  in  DATA_WIDTH  plaintext word
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO not full
- enc_req  in  1  Encrypter reqIn (Encrypter wants input)
- enc_data  out  DATA_WIDTH  to Encrypter dataIn
- enc_rot  out  ROT_WIDTH  to Encrypter rot_offset
- enc_rdy  out  1  to Encrypter rdyIn; 1-cycle pulse
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- busy  out  1  high in any state except IDLE_NOKEY and IDLE_READY with an empty FIFO
- overflow  out  1  sticky; set on s_valid while the FIFO is full

Behaviour:
- Reset is asynchronous. Reset values:
  - enc_data=0, enc_rot=0, enc_rdy=0, overflow=0, busy=0.
  - FIFO empty, fifo_count=0, s_ready=1.
  - Rotation counter=0, key register=0.
  - State = IDLE_NOKEY.
- FIFO:
  - Push on s_valid && s_ready.
  - Pop on entry to SEND_DATA.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - s_ready = (count != FIFO_DEPTH), registered-free.
- Key capture:
  - key_load captures key_in.
  - Sets key_pending in any state.
  - A repeated key_load before the key is sent overwrites the captured key; only the last key is sent.
- States:
  - IDLE_NOKEY: wait for key_pending. Then go to WAIT_REQ_K.
  - WAIT_REQ_K: when enc_req==1, drive enc_data=key and pulse enc_rdy for 1 cycle; clear key_pending; go to HOLD_K.
  - HOLD_K: hold enc_data for HOLD_CYCLES. Then go to IDLE_READY.
  - IDLE_READY:
    - key_pending has priority: go to WAIT_REQ_K.
    - Otherwise, if the FIFO is non-empty, go to WAIT_REQ_D.
  - WAIT_REQ_D: when enc_req==1, go to SEND_DATA.
  - SEND_DATA (1 cycle):
    - Pop the FIFO head into enc_data.
    - enc_rot = rotation counter.
    - enc_rdy=1.
    - Rotation counter increments, wrapping modulo 2^ROT_WIDTH.
    - Go to HOLD_D.
  - HOLD_D: hold enc_data and enc_rot for HOLD_CYCLES. Then go to IDLE_READY.
- Latency: minimum 2 cycles from FIFO non-empty with enc_req high to the enc_rdy pulse.
- enc_data and enc_rot are registered and change only in SEND_DATA or in the key-send cycle.
- enc_rdy is never high on two consecutive cycles.
- A new key (key send) resets the rotation counter to 0 in the same cycle as its enc_rdy pulse.
- Reset mid-operation: the FIFO contents and the pending key are discarded. The host must reload the key after reset.
- overflow clears only on reset.

Optional Feature:
- Macro FEEDER_LFSR_ROT_EN.
- Defined:
  - The rotation counter is replaced by a 16-bit Fibonacci LFSR (taps 16,14,13,11).
  - Seed 16'hACE1 on reset and on each key send.
  - The LFSR steps once per SEND_DATA.
  - enc_rot = the low ROT_WIDTH bits of the LFSR before the step.
- Undefined: incrementing counter as described in Behaviour.

Decomposition:
- Shared package feeder_pkg:
  - State enum type (7 states).
  - DATA_WIDTH/ROT_WIDTH defaults tied to ENCRYPTER_WIDTH/KEY_ROTATION_WIDTH.
  - LFSR seed and tap constants.
- One sub-module: feeder_fifo (synchronous FIFO with count, full/empty flags, async reset). Rotation generation stays inline.

Test Plan:
- Key send: reset; key_load with key_in=32'hDEADBEEF; enc_req=1 -> one enc_rdy pulse with enc_data=32'hDEADBEEF; enc_data holds 2 cycles; state reaches IDLE_READY.
- Data stream: after key, push 3 words 1,2,3; enc_req=1 -> three enc_rdy pulses, enc_data 1,2,3 with enc_rot 0,1,2; fifo_count ends at 0.
- Full/overflow: enc_req=0; push 9 words with FIFO_DEPTH=8 -> s_ready=0 after the 8th, overflow=1, fifo_count=8; then enc_req=1 drains the 8 words in order.
- Rotation wrap: send 33 data words -> enc_rot 0..31 then 0; a mid-stream key_load -> next key pulse, and the following data word gets enc_rot=0.
- Reset mid-hold: assert reset during HOLD_D with 2 words queued -> all outputs at reset values immediately; fifo_count=0; no enc_rdy until a new key_load.
- FEEDER_LFSR_ROT_EN defined: key then 2 words -> enc_rot = low 5 bits of 16'hACE1 (=5'h01), then the low 5 bits of the next LFSR state.
